window_reader_l1: RTL and testbench

Layer-1 sliding-window reader: consumes the channel-interleaved pixel stream and the two row-delayed streams from the external layer-1 row delay lines, and presents one 3x3 window per channel per valid output position to the convolution array. It owns the per-row short tap registers, the frame position counters, and the border gating that the free-running delay lines do not provide.

---
 rtl/l1_pkg.sv | 30 +++
 rtl/window_reader_l1_if.sv | 38 +++
 rtl/l1_tap_row.sv | 50 +++++
 rtl/window_reader_l1.sv | 206 ++++++++++++++++++++
 tb/tb_window_reader_l1.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/l1_pkg.sv
// l1_pkg: shared constants for the layer-1 sliding-window reader.
//   IMG_W, IMG_H : default frame geometry in pixels / rows
//   K            : window size (3x3)
//   CH           : channels interleaved per pixel, channel 0 first
//   DATA_W       : word width
//   LINE_DEPTH   : depth of each external row delay line
//   win_idx()    : flat element index of window element (r,c), r=0 top, c=0 left
package l1_pkg;

  localparam int IMG_W      = 200;
  localparam int IMG_H      = 200;
  localparam int K          = 3;
  localparam int CH         = 6;
  localparam int DATA_W     = 16;
  localparam int LINE_DEPTH = (IMG_W - K) * CH;

  localparam int WIN_ELEMS  = K * K;
  localparam int WIN_TL     = 0;
  localparam int WIN_BR     = WIN_ELEMS - 1;

  function automatic int win_idx(input int r, input int c);
    return r * K + c;
  endfunction

  // Delay-line depth for a geometry other than the package default.
  function automatic int line_depth(input int img_w, input int ch);
    return (img_w - K) * ch;
  endfunction

endpackage

// File: rtl/window_reader_l1_if.sv
// window_reader_l1_if: pixel-stream input and window output bundle.
//   in_valid / in_sof / in_data : channel-interleaved pixel stream
//   out_valid / out_ch / out_win: one 3x3 window per channel per position
//   err                         : one-cycle contiguity-violation pulse
//   out_eof                     : last window of frame (only with L1_WIN_EOF_EN)
// Modports: master drives the stream and observes windows; slave is the reader.
interface window_reader_l1_if #(
  parameter int DATA_W = l1_pkg::DATA_W
);

  logic                  in_valid;
  logic                  in_sof;
  logic [DATA_W-1:0]     in_data;
  logic                  out_valid;
  logic [2:0]            out_ch;
  logic [9*DATA_W-1:0]   out_win;
  logic                  err;
`ifdef L1_WIN_EOF_EN
  logic                  out_eof;
`endif

  modport master (
`ifdef L1_WIN_EOF_EN
    input  out_eof,
`endif
    output in_valid, in_sof, in_data,
    input  out_valid, out_ch, out_win, err
  );

  modport slave (
`ifdef L1_WIN_EOF_EN
    output out_eof,
`endif
    input  in_valid, in_sof, in_data,
    output out_valid, out_ch, out_win, err
  );

endinterface

// File: rtl/l1_tap_row.sv
// l1_tap_row: K*CH-word shift register for one window row, shifting every cycle.
//   clk, rst_n : clock, async active-low reset (clears all words)
//   din        : word entering this cycle (tap 0)
//   tap0       : din itself
//   tap_ch     : word that entered CH cycles ago (one pixel back)
//   tap_2ch    : word that entered 2*CH cycles ago (two pixels back)
//   oldest     : word that entered K*CH cycles ago; feeds the next delay line
module l1_tap_row #(
  parameter int CH     = 6,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] tap0,
  output logic [DATA_W-1:0] tap_ch,
  output logic [DATA_W-1:0] tap_2ch,
  output logic [DATA_W-1:0] oldest
);
  import l1_pkg::*;

  localparam int LEN = K * CH;

  // sr_q[i] holds the word that entered i+1 cycles ago.
  logic [DATA_W-1:0] sr_q [LEN];
  logic [DATA_W-1:0] sr_d [LEN];

  always_comb begin
    sr_d[0] = din;
    for (int i = 1; i < LEN; i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LEN; i++) begin
        sr_q[i] <= '0;
      end
    end else begin
      sr_q <= sr_d;
    end
  end

  assign tap0    = din;
  assign tap_ch  = sr_q[CH-1];
  assign tap_2ch = sr_q[2*CH-1];
  assign oldest  = sr_q[LEN-1];

endmodule

// File: rtl/window_reader_l1.sv
// window_reader_l1: layer-1 sliding-window reader.
// Consumes the pixel stream plus the two row-delayed streams from the external
// delay lines and presents a 3x3 window per channel for every in-frame sample
// with row>=2 and col>=2, one cycle after the sample is accepted.
//   clk, rst_n           : clock, async active-low reset
//   bus (slave)          : in_valid/in_sof/in_data, out_valid/out_ch/out_win/err
//   line0_out / line0_in : to / from delay line 0 (row2 -> row1)
//   line1_out / line1_in : to / from delay line 1 (row1 -> row0)
// Build option: define L1_WIN_EOF_EN to add bus.out_eof, high with out_valid
// on the last window of a frame.
//
// state     | meaning
// ST_IDLE   | waiting for sof; stream words shift through taps but are ignored
// ST_FRAME  | counting samples; in_valid must stay high every cycle
module window_reader_l1 #(
  parameter int IMG_W  = l1_pkg::IMG_W,
  parameter int IMG_H  = l1_pkg::IMG_H,
  parameter int CH     = l1_pkg::CH,
  parameter int DATA_W = l1_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  window_reader_l1_if.slave bus,
  output logic [DATA_W-1:0] line0_out,
  input  logic [DATA_W-1:0] line0_in,
  output logic [DATA_W-1:0] line1_out,
  input  logic [DATA_W-1:0] line1_in
);
  import l1_pkg::*;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FRAME = 1'b1;

  localparam int CHW  = (CH > 1) ? $clog2(CH) : 1;
  localparam int COLW = $clog2(IMG_W);
  localparam int ROWW = $clog2(IMG_H);

  localparam logic [CHW-1:0]  CH_LAST  = CHW'(CH - 1);
  localparam logic [COLW-1:0] COL_LAST = COLW'(IMG_W - 1);
  localparam logic [ROWW-1:0] ROW_LAST = ROWW'(IMG_H - 1);
  localparam logic [COLW-1:0] COL_MIN  = COLW'(K - 1);
  localparam logic [ROWW-1:0] ROW_MIN  = ROWW'(K - 1);

  // ---------------------------------------------------------------- tap rows
  // Row index matches window row: 0 = top (oldest image row), K-1 = current row.
  logic [DATA_W-1:0] row_din [K];
  logic [DATA_W-1:0] tap_c0  [K];
  logic [DATA_W-1:0] tap_c1  [K];
  logic [DATA_W-1:0] tap_c2  [K];
  logic [DATA_W-1:0] tap_old [K];

  assign row_din[0] = line1_in;
  assign row_din[1] = line0_in;
  assign row_din[2] = bus.in_data;

  for (genvar r = 0; r < K; r++) begin : g_row
    l1_tap_row #(
      .CH     (CH),
      .DATA_W (DATA_W)
    ) u_row (
      .clk     (clk),
      .rst_n   (rst_n),
      .din     (row_din[r]),
      .tap0    (tap_c0[r]),
      .tap_ch  (tap_c1[r]),
      .tap_2ch (tap_c2[r]),
      .oldest  (tap_old[r])
    );
  end

  // The top row's oldest word simply falls off the end.
  assign line0_out = tap_old[2];
  assign line1_out = tap_old[1];

  // ------------------------------------------------------------ state / pos
  logic [0:0]            state_q, state_d;
  logic [CHW-1:0]        ch_q, ch_d;
  logic [COLW-1:0]       col_q, col_d;
  logic [ROWW-1:0]       row_q, row_d;
  logic                  out_valid_q, out_valid_d;
  logic [2:0]            out_ch_q, out_ch_d;
  logic [9*DATA_W-1:0]   out_win_q, out_win_d;
  logic                  err_q, err_d;
`ifdef L1_WIN_EOF_EN
  logic                  out_eof_q, out_eof_d;
`endif

  logic                  accept;
  logic                  last_pos;
  logic [CHW-1:0]        cur_ch;
  logic [COLW-1:0]       cur_col;
  logic [ROWW-1:0]       cur_row;
  logic [9*DATA_W-1:0]   win_now;

  // Position of the word on the bus this cycle. sof forces (0,0,0) from either
  // state, so a mid-frame sof is a clean restart rather than an error.
  always_comb begin
    accept  = 1'b0;
    cur_ch  = ch_q;
    cur_col = col_q;
    cur_row = row_q;
    state_d = state_q;
    ch_d    = ch_q;
    col_d   = col_q;
    row_d   = row_q;
    err_d   = 1'b0;

    if (bus.in_valid && bus.in_sof) begin
      accept  = 1'b1;
      cur_ch  = '0;
      cur_col = '0;
      cur_row = '0;
    end else if (state_q == ST_FRAME) begin
      if (bus.in_valid) begin
        accept = 1'b1;
      end else begin
        // Delay lines cannot stall: a gap corrupts row alignment, so abandon
        // the frame until the next sof.
        err_d   = 1'b1;
        state_d = ST_IDLE;
        ch_d    = '0;
        col_d   = '0;
        row_d   = '0;
      end
    end

    last_pos = (cur_row == ROW_LAST) && (cur_col == COL_LAST) && (cur_ch == CH_LAST);

    if (accept) begin
      state_d = ST_FRAME;
      ch_d    = cur_ch;
      col_d   = cur_col;
      row_d   = cur_row;
      if (last_pos) begin
        state_d = ST_IDLE;
        ch_d    = '0;
        col_d   = '0;
        row_d   = '0;
      end else if (cur_ch != CH_LAST) begin
        ch_d = cur_ch + 1'b1;
      end else begin
        ch_d = '0;
        if (cur_col != COL_LAST) begin
          col_d = cur_col + 1'b1;
        end else begin
          col_d = '0;
          row_d = cur_row + 1'b1;
        end
      end
    end
  end

  // ------------------------------------------------------------ window out
  always_comb begin
    win_now = '0;
    for (int r = 0; r < K; r++) begin
      win_now[win_idx(r, 0)*DATA_W +: DATA_W] = tap_c2[r];
      win_now[win_idx(r, 1)*DATA_W +: DATA_W] = tap_c1[r];
      win_now[win_idx(r, 2)*DATA_W +: DATA_W] = tap_c0[r];
    end

    out_valid_d = accept && (cur_row >= ROW_MIN) && (cur_col >= COL_MIN);
    out_ch_d    = out_valid_d ? 3'(cur_ch) : out_ch_q;
    out_win_d   = out_valid_d ? win_now : out_win_q;
`ifdef L1_WIN_EOF_EN
    out_eof_d   = out_valid_d && last_pos;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ch_q        <= '0;
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_win_q   <= '0;
      err_q       <= 1'b0;
`ifdef L1_WIN_EOF_EN
      out_eof_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_win_q   <= out_win_d;
      err_q       <= err_d;
`ifdef L1_WIN_EOF_EN
      out_eof_q   <= out_eof_d;
`endif
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_win   = out_win_q;
  assign bus.err       = err_q;
`ifdef L1_WIN_EOF_EN
  assign bus.out_eof   = out_eof_q;
`endif

endmodule

// File: tb/tb_window_reader_l1.sv
module tb_window_reader_l1;

  localparam int W     = 8;
  localparam int H     = 6;
  localparam int C     = 2;
  localparam int DW    = 16;
  localparam int DEPTH = (W - 3) * C;
  localparam int N     = W * H * C;
  localparam int NWIN  = (H - 2) * (W - 2) * C;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [DW-1:0] line0_out, line0_in, line1_out, line1_in;
  logic [DW-1:0] dl0 [DEPTH] = '{default: '0};
  logic [DW-1:0] dl1 [DEPTH] = '{default: '0};

  window_reader_l1_if #(.DATA_W(DW)) bus ();

  window_reader_l1 #(
    .IMG_W (W),
    .IMG_H (H),
    .CH    (C),
    .DATA_W(DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .line0_out (line0_out),
    .line0_in  (line0_in),
    .line1_out (line1_out),
    .line1_in  (line1_in)
  );

  always #5 clk = ~clk;

  // Behavioural free-running delay lines, no reset, no enable.
  assign line0_in = dl0[DEPTH-1];
  assign line1_in = dl1[DEPTH-1];
  always @(posedge clk) begin
    for (int i = DEPTH - 1; i > 0; i--) begin
      dl0[i] <= dl0[i-1];
      dl1[i] <= dl1[i-1];
    end
    dl0[0] <= line0_out;
    dl1[0] <= line1_out;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: the frame as an image array plus the expected position.
  int img [H][W][C];
  bit in_frame = 0;
  int pr = 0, pc = 0, pch = 0;

  int win_cnt = 0;
  int eof_cnt = 0;
  logic [9*DW-1:0] first_w, last_w;
  logic [2:0] first_ch, last_ch;
  logic [DW-1:0] words [12];

  function automatic int pat(input int r, input int c, input int ch);
    return r * 256 + c * 16 + ch;
  endfunction

  task automatic chk(input string tag, input logic [9*DW-1:0] obs, input logic [9*DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic s, input logic [DW-1:0] d);
    logic            exp_v, exp_e, exp_eof;
    logic [2:0]      exp_ch;
    logic [9*DW-1:0] exp_w;
    int              n;
    exp_v = 1'b0; exp_e = 1'b0; exp_eof = 1'b0; exp_ch = '0; exp_w = '0;
    bus.in_valid = v;
    bus.in_sof   = s;
    bus.in_data  = d;
    if (v && s) begin
      in_frame = 1; pr = 0; pc = 0; pch = 0;
    end
    if (in_frame && !v) begin
      exp_e = 1'b1;
      in_frame = 0;
    end else if (in_frame && v) begin
      img[pr][pc][pch] = int'(d);
      if (pr >= 2 && pc >= 2) begin
        exp_v  = 1'b1;
        exp_ch = 3'(pch);
        for (int wr = 0; wr < 3; wr++)
          for (int wc = 0; wc < 3; wc++)
            exp_w[(wr*3+wc)*DW +: DW] = DW'(img[pr-2+wr][pc-2+wc][pch]);
      end
      exp_eof = exp_v && (pr == H-1) && (pc == W-1) && (pch == C-1);
      if (pr == H-1 && pc == W-1 && pch == C-1) begin
        in_frame = 0;
      end else begin
        n   = (pr * W + pc) * C + pch + 1;
        pr  = n / (W * C);
        pc  = (n / C) % W;
        pch = n % C;
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", 144'(bus.out_valid), 144'(exp_v));
    chk("err", 144'(bus.err), 144'(exp_e));
    if (exp_v) begin
      chk("out_ch", 144'(bus.out_ch), 144'(exp_ch));
      chk("out_win", bus.out_win, exp_w);
    end
`ifdef L1_WIN_EOF_EN
    chk("out_eof", 144'(bus.out_eof), 144'(exp_eof));
    if (bus.out_eof === 1'b1) eof_cnt++;
`endif
    if (bus.out_valid === 1'b1) begin
      if (win_cnt == 0) begin
        first_w  = bus.out_win;
        first_ch = bus.out_ch;
      end
      last_w  = bus.out_win;
      last_ch = bus.out_ch;
      win_cnt++;
    end
  endtask

  task automatic send_range(input bit rnd, input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, i == 0, rnd ? DW'($urandom) : DW'(pat(i / (W*C), (i / C) % W, i % C)));
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_out_valid"}, 144'(bus.out_valid), 144'(0));
    chk({tag, "_err"}, 144'(bus.err), 144'(0));
    chk({tag, "_out_win"}, bus.out_win, 144'(0));
    chk({tag, "_line0_out"}, 144'(line0_out), 144'(0));
    chk({tag, "_line1_out"}, 144'(line1_out), 144'(0));
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_data  = '0;

    // Power-on reset values.
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    chk("reset_out_ch", 144'(bus.out_ch), 144'(0));
    rst_n = 1'b1;
    step(1'b0, 1'b0, '0);

    // Contiguous pattern frame: count, first and last window contents.
    win_cnt = 0; eof_cnt = 0;
    send_range(1'b0, N);
    step(1'b0, 1'b0, '0);
    chk("frame1_windows", 144'(win_cnt), 144'(NWIN));
    chk("first_ch", 144'(first_ch), 144'(0));
    chk("first_w00", 144'(first_w[0 +: DW]), 144'(pat(0, 0, 0)));
    chk("first_w22", 144'(first_w[8*DW +: DW]), 144'(pat(2, 2, 0)));
    chk("last_ch", 144'(last_ch), 144'(C - 1));
    chk("last_w22", 144'(last_w[8*DW +: DW]), 144'(pat(H-1, W-1, C-1)));
`ifdef L1_WIN_EOF_EN
    chk("eof_count", 144'(eof_cnt), 144'(1));
`endif

    // in_valid dropped at sample (3,4,1): err pulse, then silence until sof.
    send_range(1'b0, (3 * W + 4) * C + 1);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, DW'($urandom));
    win_cnt = 0;
    send_range(1'b1, N);
    step(1'b0, 1'b0, '0);
    chk("after_drop_windows", 144'(win_cnt), 144'(NWIN));

    // sof reasserted at (2,5,0): restart with no err, full frame follows.
    send_range(1'b1, (2 * W + 5) * C);
    win_cnt = 0;
    send_range(1'b1, N);
    step(1'b0, 1'b0, '0);
    chk("restart_windows", 144'(win_cnt), 144'(NWIN));

    // Asynchronous reset mid-frame.
    send_range(1'b1, 40);
    #2 rst_n = 1'b0;
    #1;
    check_zero_outputs("async_rst");
    in_frame = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Words without sof: ignored for windowing, still shifted into line0.
    for (int j = 0; j < 12; j++) begin
      words[j] = DW'($urandom);
      step(1'b1, 1'b0, words[j]);
      if (j >= 3 * C - 1) chk("line0_delay", 144'(line0_out), 144'(words[j - (3*C - 1)]));
    end
    step(1'b0, 1'b0, '0);

    win_cnt = 0;
    send_range(1'b1, N);
    step(1'b0, 1'b0, '0);
    chk("post_reset_windows", 144'(win_cnt), 144'(NWIN));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
